// File: rtl/bin16_to_bcd.sv
// Iterative 16-bit binary to 5-digit BCD converter (double dabble), one bit per clock.
// A conversion occupies 16 SHIFT cycles plus one DONE cycle; Bcd only changes entering DONE.
module bin16_to_bcd (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] acc_adj;
  logic [35:0] shifted;

  // Each digit at 5 or more is corrected before the shift so it carries as decimal.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_add3
      assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? (acc_q[gi*4 +: 4] + 4'd3)
                                                              : acc_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {acc_adj[18:0], shift_q, 1'b0};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = bin_i;
          acc_d   = 20'h00000;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = shifted[35:16];
        shift_d = shifted[15:0];
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          bcd_d   = shifted[35:16];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= 16'h0000;
      acc_q   <= 20'h00000;
      cnt_q   <= 5'd0;
      bcd_q   <= 20'h00000;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_bin16_to_bcd.sv
// Directed and sampled-random checks of bin16_to_bcd: latency, Busy/Done timing,
// result digits, start-while-busy, mid-conversion reset and free-running restart.
module tb_bin16_to_bcd;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] bin_i;
  logic [19:0] bcd_o;
  logic        busy_o;
  logic        done_o;

  int vectors_applied = 0;
  int miscompares     = 0;

  always #5 clk_i = ~clk_i;

  bin16_to_bcd dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .bin_i   (bin_i),
    .bcd_o   (bcd_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference built from integer division, independent of the shift algorithm.
  function automatic logic [19:0] dec_ref(input int v);
    logic [19:0] r;
    int          t;
    r = 20'h0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b0;
    bin_i   = 16'h0000;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run_conv(input logic [15:0] b, input logic [19:0] exp, input string tag);
    int          cyc;
    int          busy_n;
    int          done_at;
    int          hold_err;
    logic [19:0] prev;
    @(negedge clk_i);
    bin_i   = b;
    start_i = 1'b1;
    prev    = bcd_o;
    @(negedge clk_i);
    start_i  = 1'b0;
    bin_i    = ~b;
    cyc      = 1;
    busy_n   = 0;
    done_at  = 0;
    hold_err = 0;
    while (cyc <= 40 && done_at == 0) begin
      if (busy_o) busy_n++;
      if (done_o) done_at = cyc;
      else if (bcd_o !== prev) hold_err++;
      if (done_at == 0) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    check({tag, " latency"}, done_at, 17);
    check({tag, " busy_cycles"}, busy_n, 16);
    check({tag, " bcd_hold"}, hold_err, 0);
    check({tag, " bcd"}, {12'h0, bcd_o}, {12'h0, exp});
    @(negedge clk_i);
    check({tag, " done_width"}, {31'h0, done_o}, 32'h0);
    check({tag, " idle_busy"}, {31'h0, busy_o}, 32'h0);
    $display("conv %s bin=%0d bcd=%05h exp=%05h", tag, b, bcd_o, exp);
  endtask

  initial begin
    int          n_done;
    int          first_done;
    int          second_done;
    logic [15:0] rv;

    rst_i   = 1'b1;
    start_i = 1'b0;
    bin_i   = 16'h0000;
    do_reset();
    @(negedge clk_i);
    check("reset bcd", {12'h0, bcd_o}, 32'h0);
    check("reset busy", {31'h0, busy_o}, 32'h0);
    check("reset done", {31'h0, done_o}, 32'h0);

    run_conv(16'd0,     20'h00000, "zero");
    run_conv(16'd9,     20'h00009, "nine");
    run_conv(16'd10,    20'h00010, "ten");
    run_conv(16'd19,    20'h00019, "nineteen");
    run_conv(16'd20,    20'h00020, "twenty");
    run_conv(16'hFFFF,  20'h65535, "max");
    run_conv(16'd40960, 20'h40960, "40960");
    run_conv(16'd9999,  20'h09999, "9999");
    run_conv(16'd10000, 20'h10000, "10000");

    // Start and a new Bin during SHIFT must be ignored.
    @(negedge clk_i);
    bin_i   = 16'd1234;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    n_done     = 0;
    first_done = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        bin_i   = 16'd9999;
        start_i = 1'b1;
      end
      if (c == 6) start_i = 1'b0;
      if (done_o) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      @(negedge clk_i);
    end
    check("busy_start done_count", n_done, 1);
    check("busy_start done_cycle", first_done, 17);
    check("busy_start bcd", {12'h0, bcd_o}, 32'h01234);
    $display("conv busy_start bin=1234 bcd=%05h", bcd_o);

    // Reset in the middle of a conversion aborts it without a Done pulse.
    @(negedge clk_i);
    bin_i   = 16'd5000;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 1; c < 8; c++) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort bcd", {12'h0, bcd_o}, 32'h0);
    check("abort busy", {31'h0, busy_o}, 32'h0);
    check("abort done", {31'h0, done_o}, 32'h0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o) n_done++;
      @(negedge clk_i);
    end
    check("abort no_done", n_done, 0);
    $display("conv abort bin=5000 bcd=%05h", bcd_o);
    run_conv(16'd42, 20'h00042, "after_abort");

    // Start held high: free-running restart every 18 cycles.
    @(negedge clk_i);
    bin_i   = 16'd7;
    start_i = 1'b1;
    n_done      = 0;
    first_done  = 0;
    second_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        n_done++;
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
    end
    start_i = 1'b0;
    check("hold_start done_count", n_done, 2);
    check("hold_start first_done", first_done, 17);
    check("hold_start second_done", second_done, 35);
    check("hold_start bcd", {12'h0, bcd_o}, 32'h00007);
    $display("conv hold_start bin=7 bcd=%05h", bcd_o);
    for (int c = 0; c < 40 && (busy_o || done_o); c++) @(negedge clk_i);
    check("hold_start drained", {30'h0, busy_o, done_o}, 32'h0);

    // Sampled sweep against the decimal reference.
    for (int i = 0; i < 120; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, dec_ref(int'(rv)), "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
